// File: rtl/if_id_stage_if.sv
// Fetch/decode handshake bundle for the IF/ID pipeline register.
// master = fetch+decode side, slave = if_id_stage.
interface if_id_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] instr_in;
  logic            fetch_en;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misalign;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;

  modport master (
    output in_valid, pc_in, instr_in,
    output flush, out_ready,
    input  fetch_en, out_valid, out_pc,
    input  out_instr, out_misalign,
    input  opcode, rd, funct3,
    input  rs1, rs2, funct7
  );

  modport slave (
    input  in_valid, pc_in, instr_in,
    input  flush, out_ready,
    output fetch_en, out_valid, out_pc,
    output out_instr, out_misalign,
    output opcode, rd, funct3,
    output rs1, rs2, funct7
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID register with 2-entry skid buffer, flush and field split.
// Optional IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_stage #(
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013,
  parameter int              CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            mis;
  } slot_t;

  slot_t out_q, out_d;
  slot_t skid_q, skid_d;
  slot_t in_e;
  logic  accept;
  logic  drain;

  assign accept = bus.in_valid & ~skid_q.v;
  assign drain  = out_q.v & bus.out_ready;

  always_comb begin
    in_e.v     = accept;
    in_e.pc    = bus.pc_in;
    in_e.instr = bus.instr_in;
    in_e.mis   = |bus.pc_in[1:0];
  end

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (bus.flush) begin
      out_d.v  = 1'b0;
      skid_d.v = 1'b0;
    end else if (!out_q.v || drain) begin
      if (skid_q.v) begin
        out_d  = skid_q;
        skid_d = in_e;
      end else if (accept) begin
        out_d = in_e;
      end else begin
        out_d.v = 1'b0;
      end
    end else if (accept) begin
      skid_d = in_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '{v: 1'b0, pc: '0, instr: NOP, mis: 1'b0};
      skid_q <= '{v: 1'b0, pc: '0, instr: NOP, mis: 1'b0};
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  // fetch_en depends only on flop state, never on out_ready
  assign bus.fetch_en     = ~skid_q.v;
  assign bus.out_valid    = out_q.v;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_instr    = out_q.v ? out_q.instr : NOP;
  assign bus.out_misalign = out_q.v & out_q.mis;

  assign bus.opcode = bus.out_instr[6:0];
  assign bus.rd     = bus.out_instr[11:7];
  assign bus.funct3 = bus.out_instr[14:12];
  assign bus.rs1    = bus.out_instr[19:15];
  assign bus.rs2    = bus.out_instr[24:20];
  assign bus.funct7 = bus.out_instr[31:25];

`ifdef IF_ID_PERF_EN
  logic kill;
  assign kill = bus.flush &
                (out_q.v | skid_q.v | accept);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_q.v && !bus.out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (kill && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
